// File: rtl/video_timing_gen.sv
// Raster timing generator: owns the horizontal/vertical pixel counters and
// produces registered sync, display-enable and line/frame start strobes that
// are all aligned with the counter values presented in the same cycle.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned H_W      = 11,
    parameter int unsigned V_W      = 10
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           ce,
    output logic [H_W-1:0] hCount,
    output logic [V_W-1:0] vCount,
    output logic           hSync,
    output logic           vSync,
    output logic           de,
    output logic           lineStart,
    output logic           frameStart
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Decode boundaries, all at counter width so comparisons stay unsigned.
    localparam logic [H_W-1:0] H_MAX   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_VIS   = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_SS    = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] H_SE    = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0] V_MAX   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_VIS   = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_SS    = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] V_SE    = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [H_W-1:0] h_nx;
    logic [V_W-1:0] v_nx;
    logic           h_wrap;
    logic           v_wrap;
    logic           hs_act;
    logic           vs_act;
    logic           de_nx;

    // Next counter position and the decode of that position.
    always_comb begin
        h_wrap = (hCount == H_MAX);
        v_wrap = (vCount == V_MAX);
        h_nx   = h_wrap ? '0 : hCount + 1'b1;
        v_nx   = vCount;
        if (h_wrap) begin
            v_nx = v_wrap ? '0 : vCount + 1'b1;
        end
        hs_act = (h_nx >= H_SS) && (h_nx <= H_SE);
        vs_act = (v_nx >= V_SS) && (v_nx <= V_SE);
        de_nx  = (h_nx < H_VIS) && (v_nx < V_VIS);
    end

    // Counters and outputs advance together on ce; strobes last one clk.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hCount     <= H_MAX;
            vCount     <= V_MAX;
            hSync      <= ~H_POL;
            vSync      <= ~V_POL;
            de         <= 1'b0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end else if (ce) begin
            hCount     <= h_nx;
            vCount     <= v_nx;
            hSync      <= hs_act ? H_POL : ~H_POL;
            vSync      <= vs_act ? V_POL : ~V_POL;
            de         <= de_nx;
            lineStart  <= (h_nx == '0);
            frameStart <= (h_nx == '0) && (v_nx == '0);
        end else begin
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a small-config instance exercised by a vector
// table and randomized ce/reset traffic, plus a default 800x600 instance
// checked around reset release and the first lines.
module tb_video_timing_gen;

    typedef struct {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        bit hp, vp;
    } cfg_t;

    typedef struct {
        int pos;  // linear raster position, line-major
        bit rst;  // still holding the reset values
        bit stb;  // previous edge advanced the raster
    } ms_t;

    typedef struct {
        int h, v;
        bit hs, vs, de, ls, fs;
    } outs_t;

    typedef struct {
        bit    rn;
        bit    ce;
        int    n;
        outs_t e;
    } vec_t;

    cfg_t cs = '{ha:8, hfp:2, hsw:2, hbp:2, va:4, vfp:1, vsw:1, vbp:1, hp:1'b1, vp:1'b1};
    cfg_t cd = '{ha:800, hfp:40, hsw:128, hbp:88, va:600, vfp:1, vsw:4, vbp:23,
                 hp:1'b0, vp:1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_resetn = 1'b0, s_ce = 1'b0;
    logic [3:0]  s_h;
    logic [2:0]  s_v;
    logic        s_hs, s_vs, s_de, s_ls, s_fs;
    logic        d_resetn = 1'b0, d_ce = 1'b0;
    logic [10:0] d_h;
    logic [9:0]  d_v;
    logic        d_hs, d_vs, d_de, d_ls, d_fs;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .H_W(4), .V_W(3)
    ) dut_s (
        .clk(clk), .resetn(s_resetn), .ce(s_ce),
        .hCount(s_h), .vCount(s_v), .hSync(s_hs), .vSync(s_vs), .de(s_de),
        .lineStart(s_ls), .frameStart(s_fs)
    );

    video_timing_gen dut_d (
        .clk(clk), .resetn(d_resetn), .ce(d_ce),
        .hCount(d_h), .vCount(d_v), .hSync(d_hs), .vSync(d_vs), .de(d_de),
        .lineStart(d_ls), .frameStart(d_fs)
    );

    int nerr = 0;
    int nchk = 0;
    ms_t ms_s = '{pos:97, rst:1'b1, stb:1'b0};
    ms_t ms_d = '{pos:663167, rst:1'b1, stb:1'b0};

    function automatic int htot(cfg_t c);
        return c.ha + c.hfp + c.hsw + c.hbp;
    endfunction

    function automatic int vtot(cfg_t c);
        return c.va + c.vfp + c.vsw + c.vbp;
    endfunction

    // Reference: the raster is a linear sequence of positions advanced by ce.
    function automatic ms_t mstep(cfg_t c, ms_t s, bit rn, bit ce);
        ms_t r = s;
        int tot = htot(c) * vtot(c);
        if (!rn) begin
            r.rst = 1'b1;
            r.pos = tot - 1;
            r.stb = 1'b0;
        end else if (ce) begin
            r.pos = s.rst ? 0 : (s.pos + 1) % tot;
            r.rst = 1'b0;
            r.stb = 1'b1;
        end else begin
            r.stb = 1'b0;
        end
        return r;
    endfunction

    function automatic outs_t mexp(cfg_t c, ms_t s);
        outs_t o;
        o.h = s.pos % htot(c);
        o.v = s.pos / htot(c);
        if (s.rst) begin
            o.hs = ~c.hp;
            o.vs = ~c.vp;
            o.de = 1'b0;
            o.ls = 1'b0;
            o.fs = 1'b0;
        end else begin
            o.hs = (o.h >= c.ha + c.hfp && o.h < c.ha + c.hfp + c.hsw) ? c.hp : ~c.hp;
            o.vs = (o.v >= c.va + c.vfp && o.v < c.va + c.vfp + c.vsw) ? c.vp : ~c.vp;
            o.de = (o.h < c.ha) && (o.v < c.va);
            o.ls = s.stb && (o.h == 0);
            o.fs = s.stb && (o.h == 0) && (o.v == 0);
        end
        return o;
    endfunction

    function automatic outs_t act_s();
        outs_t o;
        o.h = int'(s_h);
        o.v = int'(s_v);
        o.hs = s_hs; o.vs = s_vs; o.de = s_de; o.ls = s_ls; o.fs = s_fs;
        return o;
    endfunction

    function automatic outs_t act_d();
        outs_t o;
        o.h = int'(d_h);
        o.v = int'(d_v);
        o.hs = d_hs; o.vs = d_vs; o.de = d_de; o.ls = d_ls; o.fs = d_fs;
        return o;
    endfunction

    function automatic outs_t mk_o(int h, int v, bit hs, bit vs, bit de, bit ls, bit fs);
        outs_t o;
        o.h = h; o.v = v; o.hs = hs; o.vs = vs; o.de = de; o.ls = ls; o.fs = fs;
        return o;
    endfunction

    function automatic vec_t mk(bit rn, bit ce, int n, int h, int v, bit hs, bit vs,
                                bit de, bit ls, bit fs);
        vec_t t;
        t.rn = rn; t.ce = ce; t.n = n;
        t.e = mk_o(h, v, hs, vs, de, ls, fs);
        return t;
    endfunction

    task automatic cmp_f(string tag, string f, int a, int e);
        nchk++;
        if (a != e) begin
            nerr++;
            $display("FAIL %s.%s got=%0d want=%0d at %0t", tag, f, a, e, $time);
        end
    endtask

    task automatic cmp(string tag, outs_t a, outs_t e);
        cmp_f(tag, "hCount", a.h, e.h);
        cmp_f(tag, "vCount", a.v, e.v);
        cmp_f(tag, "hSync", int'(a.hs), int'(e.hs));
        cmp_f(tag, "vSync", int'(a.vs), int'(e.vs));
        cmp_f(tag, "de", int'(a.de), int'(e.de));
        cmp_f(tag, "lineStart", int'(a.ls), int'(e.ls));
        cmp_f(tag, "frameStart", int'(a.fs), int'(e.fs));
    endtask

    // One clk edge; the models see the same inputs as the DUTs.
    task automatic step();
        @(posedge clk);
        ms_s = mstep(cs, ms_s, s_resetn, s_ce);
        ms_d = mstep(cd, ms_d, d_resetn, d_ce);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        int hs_low;
        int de_cnt;
        int ce_mode;

        // Small config: hSync high 10..11, vSync high at line 5, H_TOTAL=14, V_TOTAL=7.
        tbl.push_back(mk(0, 1, 1,  13, 6, 0, 0, 0, 0, 0));  // reset values
        tbl.push_back(mk(1, 0, 3,  13, 6, 0, 0, 0, 0, 0));  // released, no ce yet
        tbl.push_back(mk(1, 1, 1,   0, 0, 0, 0, 1, 1, 1));  // first ce lands on (0,0)
        tbl.push_back(mk(1, 0, 1,   0, 0, 0, 0, 1, 0, 0));  // strobes drop on ce gap
        tbl.push_back(mk(1, 1, 7,   7, 0, 0, 0, 1, 0, 0));  // last visible pixel
        tbl.push_back(mk(1, 1, 1,   8, 0, 0, 0, 0, 0, 0));  // front porch
        tbl.push_back(mk(1, 1, 2,  10, 0, 1, 0, 0, 0, 0));  // sync start
        tbl.push_back(mk(1, 1, 1,  11, 0, 1, 0, 0, 0, 0));  // sync end
        tbl.push_back(mk(1, 1, 1,  12, 0, 0, 0, 0, 0, 0));  // back porch
        tbl.push_back(mk(1, 1, 1,  13, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1,   0, 1, 0, 0, 1, 1, 0));  // line wrap
        tbl.push_back(mk(1, 1, 56,  0, 5, 0, 1, 0, 1, 0));  // vsync line
        tbl.push_back(mk(1, 1, 3,   3, 5, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 11,  0, 6, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 13, 13, 6, 0, 0, 0, 0, 0));  // last position of frame
        tbl.push_back(mk(1, 0, 5,  13, 6, 0, 0, 0, 0, 0));  // ce low across wrap
        tbl.push_back(mk(1, 1, 1,   0, 0, 0, 0, 1, 1, 1));  // one frameStart
        tbl.push_back(mk(1, 0, 1,   0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 5,   5, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1,  13, 6, 0, 0, 0, 0, 0));  // mid-frame reset
        tbl.push_back(mk(1, 1, 1,   0, 0, 0, 0, 1, 1, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            s_resetn = tbl[i].rn;
            s_ce     = tbl[i].ce;
            repeat (tbl[i].n) step();
            cmp($sformatf("tbl%0d", i), act_s(), tbl[i].e);
        end

        // Randomized ce patterns and occasional resets against the raster model.
        for (int seg = 0; seg < 8; seg++) begin
            ce_mode = seg % 4;
            for (int k = 0; k < 500; k++) begin
                s_resetn = ($urandom_range(0, 249) != 0);
                case (ce_mode)
                    0: s_ce = 1'b1;
                    1: s_ce = k[0];
                    2: s_ce = ($urandom_range(0, 1) != 0);
                    default: s_ce = ($urandom_range(0, 4) == 0);
                endcase
                step();
                cmp("rand", act_s(), mexp(cs, ms_s));
            end
        end

        // Default 800x600 timing around reset release and the first lines.
        s_resetn = 1'b0;
        d_resetn = 1'b0;
        d_ce     = 1'b1;
        step();
        cmp("d_rst", act_d(), mk_o(1055, 627, 1, 1, 0, 0, 0));
        d_resetn = 1'b1;
        d_ce     = 1'b0;
        repeat (2) step();
        cmp("d_hold", act_d(), mk_o(1055, 627, 1, 1, 0, 0, 0));
        d_ce = 1'b1;
        step();
        cmp("d_first", act_d(), mk_o(0, 0, 1, 1, 1, 1, 1));
        hs_low = (d_hs == 1'b0) ? 1 : 0;
        de_cnt = d_de ? 1 : 0;
        for (int k = 1; k < 6 * 1056; k++) begin
            step();
            cmp("d_run", act_d(), mexp(cd, ms_d));
            if (d_hs == 1'b0) hs_low++;
            if (d_de) de_cnt++;
        end
        cmp("d_eol", act_d(), mk_o(1055, 5, 1, 1, 0, 0, 0));
        cmp_f("d_hs_low", "count", hs_low, 6 * 128);
        cmp_f("d_de", "count", de_cnt, 6 * 800);
        step();
        cmp("d_wrap", act_d(), mk_o(0, 6, 1, 1, 1, 1, 0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
